// File: rtl/adder_result_stage.sv
// Result buffer behind a 32-bit adder. Each entry stores the sum, the carry-out and
// flags computed at push time, and entries leave in FIFO order to a ready/valid consumer.
module adder_result_stage #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_sum,
   input  logic        in_cout,
   input  logic        in_a_msb,
   input  logic        in_b_msb,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_sum,
   output logic        out_cout,
   output logic        out_zero,
   output logic        out_neg,
   output logic        out_ovf,
   output logic [15:0] result_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

   logic [31:0]   r_sum  [DEPTH];
   logic [3:0]    r_flag [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [15:0]   r_res_cnt;
   logic          r_run;

   logic          w_push;
   logic          w_pop;
   logic [3:0]    w_flag;
   logic [3:0]    w_head_flag;

   // r_run keeps in_ready low while in reset and for the edge that releases it
   assign in_ready  = r_run & (r_count < C_DEPTH);
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   // flag order: cout, zero, neg, ovf
   assign w_flag = {in_cout,
                    (in_sum == 32'h0000_0000),
                    in_sum[31],
                    (in_a_msb == in_b_msb) & (in_sum[31] != in_a_msb)};

   assign w_head_flag = r_flag[r_rptr];

   assign out_sum      = out_valid ? r_sum[r_rptr] : 32'h0000_0000;
   assign out_cout     = out_valid & w_head_flag[3];
   assign out_zero     = out_valid & w_head_flag[2];
   assign out_neg      = out_valid & w_head_flag[1];
   assign out_ovf      = out_valid & w_head_flag[0];
   assign result_count = r_res_cnt;

   // payload storage needs no reset: every output is masked while empty
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_sum[r_wptr]  <= in_sum;
         r_flag[r_wptr] <= w_flag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_res_cnt <= 16'h0000;
         r_run     <= 1'b0;
      end else begin
         r_run <= 1'b1;
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_pop && (r_res_cnt != 16'hFFFF)) r_res_cnt <= r_res_cnt + 16'h0001;
      end
   end

endmodule

// File: tb/tb_adder_result_stage.sv
// Directed bench for adder_result_stage: a negedge monitor scoreboards every transfer
// while the initial block walks through reset, flag, fill, stream and saturation cases.
module tb_adder_result_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_sum;
   logic        in_cout;
   logic        in_a_msb;
   logic        in_b_msb;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic        out_cout;
   logic        out_zero;
   logic        out_neg;
   logic        out_ovf;
   logic [15:0] result_count;

   typedef struct {
      logic [31:0] sum;
      logic [3:0]  fl;
   } exp_t;

   exp_t q[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   bit   sb_en    = 1'b1;

   adder_result_stage #(.DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sum(in_sum), .in_cout(in_cout), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_zero(out_zero),
      .out_neg(out_neg), .out_ovf(out_ovf),
      .result_count(result_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] s, input logic c, input logic a, input logic b);
      exp_t e;
      e.sum = s;
      e.fl  = {c, (s == 32'd0), s[31], (a == b) && (s[31] != a)};
      return e;
   endfunction

   // Scoreboard: compare the head on a pop, then record any accepted push.
   always @(negedge clk) begin
      if (!rst && sb_en) begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("sb_underflow", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("pop_sum", out_sum, e.sum);
               chk("pop_flags", {28'd0, out_cout, out_zero, out_neg, out_ovf}, {28'd0, e.fl});
            end
         end
         if (in_valid && in_ready) q.push_back(model(in_sum, in_cout, in_a_msb, in_b_msb));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] s, input logic c, input logic a, input logic b);
      in_valid = 1'b1;
      in_sum   = s;
      in_cout  = c;
      in_a_msb = a;
      in_b_msb = b;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      q.delete();
      rst = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_sum = 32'd0; in_cout = 1'b0; in_a_msb = 1'b0; in_b_msb = 1'b0;
      step();
      step();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {27'd0, out_cout, out_zero, out_neg, out_ovf, |out_sum}, 32'd0);
      chk("rst_count", {16'd0, result_count}, 32'd0);
      rst = 1'b0;
      chk("rel_in_ready_before_edge", {31'd0, in_ready}, 32'd0);
      step();
      chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

      // pop request while empty must be ignored
      out_ready = 1'b1;
      step();
      step();
      chk("empty_pop_count", {16'd0, result_count}, 32'd0);
      chk("empty_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b0;

      // single push of zero sum
      drive(32'h0000_0000, 1'b1, 1'b0, 1'b0);
      step();
      in_valid = 1'b0;
      chk("single_valid", {31'd0, out_valid}, 32'd1);
      chk("single_flags", {28'd0, out_cout, out_zero, out_neg, out_ovf}, 32'b1100);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("single_drained", {31'd0, out_valid}, 32'd0);
      chk("single_count", {16'd0, result_count}, 32'd1);

      // overflow cases, head held stable under back-pressure
      do_reset();
      drive(32'h8000_0000, 1'b0, 1'b0, 1'b0);
      step();
      drive(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("stall_sum", out_sum, 32'h8000_0000);
         chk("stall_neg_ovf", {30'd0, out_neg, out_ovf}, 32'b11);
         step();
      end
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("ovf2_sum", out_sum, 32'h7FFF_FFFF);
      chk("ovf2_neg_ovf", {30'd0, out_neg, out_ovf}, 32'b01);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // fill, drop while full even with a pop, then drain
      do_reset();
      drive(32'h11, 1'b0, 1'b0, 1'b0);
      step();
      drive(32'h22, 1'b0, 1'b0, 1'b0);
      step();
      chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
      drive(32'h33, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("fill_ready_after_pop", {31'd0, in_ready}, 32'd1);
      chk("fill_head", out_sum, 32'h22);
      for (int i = 0; i < 3; i++) step();
      out_ready = 1'b0;
      chk("fill_empty", {31'd0, out_valid}, 32'd0);
      chk("fill_count", {16'd0, result_count}, 32'd2);

      // streaming 100 results
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         drive(32'(i), i[0], i[1], i[2]);
         step();
         chk("stream_no_gap", {31'd0, out_valid}, 32'd1);
      end
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      chk("stream_count", {16'd0, result_count}, 32'd100);
      chk("stream_empty", {31'd0, out_valid}, 32'd0);

      // reset with two entries buffered
      do_reset();
      drive(32'h1, 1'b0, 1'b0, 1'b0);
      step();
      drive(32'h2, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b1;
      step();
      chk("simul_head", out_sum, 32'h2);
      chk("simul_ready_valid", {30'd0, in_ready, out_valid}, 32'b11);
      chk("simul_count", {16'd0, result_count}, 32'd1);
      out_ready = 1'b0;
      drive(32'h3, 1'b0, 1'b0, 1'b0);
      step();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("midrst_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_count", {16'd0, result_count}, 32'd0);
      chk("midrst_ready_sum", {31'd0, in_ready} | out_sum, 32'd0);
      q.delete();
      step();
      rst = 1'b0;
      step();
      drive(32'hA5A5_A5A5, 1'b0, 1'b1, 1'b0);
      step();
      in_valid = 1'b0;
      chk("midrst_first", out_sum, 32'hA5A5_A5A5);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("midrst_drained", {31'd0, out_valid}, 32'd0);

      // result_count saturation
      do_reset();
      sb_en = 1'b0;
      out_ready = 1'b1;
      drive(32'h5, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 65535; i++) step();
      chk("sat_before", {16'd0, result_count}, 32'h0000_FFFE);
      for (int i = 0; i < 5; i++) step();
      chk("sat_hold", {16'd0, result_count}, 32'h0000_FFFF);
      in_valid = 1'b0;
      step();
      step();
      out_ready = 1'b0;
      chk("sat_final", {16'd0, result_count}, 32'h0000_FFFF);
      chk("sat_empty", {31'd0, out_valid}, 32'd0);
      q.delete();
      sb_en = 1'b1;

      chk("sb_leftover", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/adder_result_stage.md
ADDER_RESULT_STAGE -- requirements
Module: adder_result_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter DEPTH, default 2, SHALL set the result-buffer entry count (power of two, >= 2).
REQ-003 Port clk, input, 1, SHALL be the rising-edge clock for all state.
REQ-004 Port rst, input, 1, SHALL be the asynchronous active-high reset.
REQ-005 Port in_valid, input, 1, SHALL flag that the upstream 32-bit adder result is valid.
REQ-006 Port in_ready, output, 1, SHALL flag that the block can accept a result this cycle.
REQ-007 Port in_sum, input, 32, SHALL carry the adder sum.
REQ-008 Port in_cout, input, 1, SHALL carry the adder carry-out.
REQ-009 Port in_a_msb, input, 1, SHALL carry bit 31 of operand a used for this sum.
REQ-010 Port in_b_msb, input, 1, SHALL carry bit 31 of operand b used for this sum.
REQ-011 Port out_valid, output, 1, SHALL flag a valid buffered result at the head.
REQ-012 Port out_ready, input, 1, SHALL flag that the downstream consumer takes the head result.
REQ-013 Port out_sum, output, 32, SHALL carry the head sum.
REQ-014 Port out_cout, output, 1, SHALL carry the head carry-out.
REQ-015 Port out_zero, output, 1, SHALL be 1 when the head sum is 0x00000000.
REQ-016 Port out_neg, output, 1, SHALL equal bit 31 of the head sum.
REQ-017 Port out_ovf, output, 1, SHALL flag signed overflow for the head result.
REQ-018 Port result_count, output, 16, SHALL count results delivered downstream.

Function
REQ-019 Push SHALL occur on a rising edge with in_valid=1 and in_ready=1; pop SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-020 in_ready SHALL equal (occupancy < DEPTH), registered-state only, with no combinational path from out_ready.
REQ-021 out_valid SHALL equal (occupancy > 0); head outputs SHALL be driven from storage, not from input ports.
REQ-022 Latency SHALL be 1 cycle: a result pushed at edge N is visible on out_* after edge N when the buffer was empty.
REQ-023 Flags SHALL be computed at push time and stored with the entry: zero = (in_sum==0), neg = in_sum[31], ovf = (in_a_msb==in_b_msb) AND (in_sum[31]!=in_a_msb).
REQ-024 Entries SHALL leave in push order (FIFO); read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 Simultaneous push and pop when 0 < occupancy < DEPTH SHALL leave occupancy unchanged and both transfers SHALL complete.
REQ-026 When full, in_ready=0 and in_valid SHALL be ignored even if a pop occurs that cycle; in_ready rises the cycle after the pop.
REQ-027 When empty, out_ready SHALL be ignored and no pop SHALL occur.
REQ-028 Head outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 result_count SHALL increment by 1 per pop and saturate at 0xFFFF.
REQ-030 When out_valid=0, out_sum, out_cout, out_zero, out_neg and out_ovf SHALL be 0.

Reset
REQ-031 While rst=1, occupancy, pointers and result_count SHALL be 0, in_ready=0, out_valid=0, all out_* data and flags 0.
REQ-032 in_ready SHALL become 1 on the first rising edge after rst deasserts.
REQ-033 Reset asserted mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.

Verification
REQ-034 Single push: in_sum=0x00000000, in_cout=1, msbs 0/0 -> next cycle out_valid=1, out_zero=1, out_cout=1, out_neg=0, out_ovf=0.
REQ-035 Overflow: in_sum=0x80000000, a_msb=0, b_msb=0 -> out_neg=1, out_ovf=1; in_sum=0x7FFFFFFF, a_msb=1, b_msb=1 -> out_ovf=1, out_neg=0.
REQ-036 Fill with DEPTH=2, out_ready=0: push 0x11, 0x22 -> in_ready=0; third in_valid with 0x33 dropped; then drain -> 0x11, 0x22 in order, result_count=2.
REQ-037 Streaming: in_valid=out_ready=1 for 100 cycles with incrementing sums -> 100 results in order, no gaps after first, result_count=100.
REQ-038 Reset mid-stream: assert rst with 2 entries buffered -> out_valid=0, result_count=0 immediately; after release, first pushed value 0xA5A5A5A5 emerges first.
REQ-039 Saturation: force 65536 pops -> result_count holds 0xFFFF.
